// File: rtl/char_uart_tx.sv
// rtl/char_uart_tx.sv - byte FIFO feeding an 8N1 LSB-first UART transmitter
module char_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            char,
  input  logic                  valid,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]      BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic                   bit_end;
  logic                   have_data;
  logic                   pop;
  logic                   push;
  logic [DEPTH_LOG2:0]    count_next;

  // The FSM takes a byte when idle or at the last cycle of a stop bit;
  // a full FIFO still accepts a write on the edge that frees a slot.
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign have_data = (fifo_count != '0);
  assign pop       = have_data && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push      = valid && ((fifo_count != FULL_COUNT) || pop);
  assign busy      = (state != IDLE);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_next = fifo_count - (DEPTH_LOG2 + 1)'(1);
      default: count_next = fifo_count;
    endcase
  end

  // Byte storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= char;
    end
  end

  // Pointers, occupancy flags and the sticky drop indicator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      fifo_count <= count_next;
      fifo_full  <= (count_next == FULL_COUNT);
      if (valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Framing FSM: start bit, eight data bits LSB first, stop bit; tx is registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_uart_tx.sv
// tb/tb_char_uart_tx.sv - self-checking bench for char_uart_tx
module tb_char_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int DL    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    char_in = 8'h00;
  logic          valid = 1'b0;
  logic          tx;
  logic          busy;
  logic [DL:0]   fifo_count;
  logic          fifo_full;
  logic          overflow;

  char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DEPTH_LOG2(DL)) dut (
    .CLK(CLK), .RST(RST), .char(char_in), .valid(valid), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: bytes expected on the line, in order, plus frame start cycles.
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames = 0;

  // Line monitor: samples each bit mid-cell, abandons a frame if busy drops.
  bit         mon_active = 0;
  int         off = 0;
  logic [9:0] bits;
  always @(negedge CLK) begin
    if (mon_active && !busy) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0 && busy === 1'b1) begin
        mon_active = 1;
        off = 0;
        bits = '0;
        start_q.push_back(cyc);
      end
    end else begin
      off++;
      if (off % CPB == CPB / 2) bits[off / CPB] = tx;
      if (off == 10 * CPB - 1) begin
        check("mon_start_bit", bits[0], 1'b0);
        check("mon_stop_bit", bits[9], 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_frame: got %0h expected none", bits[8:1]);
        end else begin
          check("mon_rx_byte", bits[8:1], exp_q.pop_front());
        end
        frames++;
        mon_active = 0;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("frames_done", frames, target);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] ch;
    logic [9:0] line_bits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    int f0;
    int s0;
    logic [7:0] burst [4];

    vecs[0] = '{8'h32, 10'b1001100100};
    vecs[1] = '{8'h41, 10'b1010000010};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    vecs[4] = '{8'hA5, 10'b1101001010};
    burst[0] = 8'h32; burst[1] = 8'h31; burst[2] = 8'h33; burst[3] = 8'h36;

    // Reset state
    do_reset(2);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_overflow", overflow, 1'b0);

    // Quiet line for 1000 cycles
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
    end

    // Single-frame vectors: latency, bit-by-bit line level, busy length
    for (int v = 0; v < 5; v++) begin
      @(negedge CLK);
      valid = 1'b1;
      char_in = vecs[v].ch;
      exp_q.push_back(vecs[v].ch);
      @(negedge CLK);
      valid = 1'b0;
      check("vec_count_after_write", fifo_count, 1);
      check("vec_tx_not_yet", tx, 1'b1);
      @(negedge CLK);
      check("vec_latency_tx_low", tx, 1'b0);
      check("vec_count_after_pop", fifo_count, 0);
      busy_cycles = busy ? 1 : 0;
      for (int o = 1; o < 10 * CPB; o++) begin
        @(negedge CLK);
        if (busy) busy_cycles++;
        if (o % CPB == CPB / 2) check("vec_line_bit", tx, vecs[v].line_bits[o / CPB]);
      end
      @(negedge CLK);
      check("vec_busy_cycles", busy_cycles, 10 * CPB);
      check("vec_busy_end", busy, 1'b0);
      check("vec_tx_end", tx, 1'b1);
      check("vec_sb_empty", exp_q.size(), 0);
    end

    // Burst of four back-to-back characters
    f0 = frames;
    s0 = start_q.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      valid = 1'b1;
      char_in = burst[i];
      exp_q.push_back(burst[i]);
    end
    @(negedge CLK);
    valid = 1'b0;
    wait_frames(f0 + 4, 300);
    for (int i = 0; i < 3; i++) begin
      if (start_q.size() > s0 + i + 1)
        check("burst_frame_spacing", start_q[s0 + i + 1] - start_q[s0 + i], 10 * CPB);
      else
        check("burst_frame_starts", start_q.size(), s0 + 4);
    end
    repeat (2) @(negedge CLK);
    check("burst_overflow", overflow, 1'b0);
    check("burst_busy_end", busy, 1'b0);
    check("burst_count_end", fifo_count, 0);
    check("burst_sb_empty", exp_q.size(), 0);

    // 18 consecutive writes: one popped early, 16 buffered, last dropped
    f0 = frames;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      if (i == 1) check("ovf_count_e1", fifo_count, 1);
      if (i == 2) begin
        check("ovf_count_e2", fifo_count, 1);
        check("ovf_busy_e2", busy, 1'b1);
      end
      if (i == 17) begin
        check("ovf_count_e17", fifo_count, DEPTH);
        check("ovf_full_e17", fifo_full, 1'b1);
        check("ovf_flag_e17", overflow, 1'b0);
      end
      valid = 1'b1;
      char_in = 8'h60 + 8'(i);
      if (i < 17) exp_q.push_back(8'h60 + 8'(i));
    end
    @(negedge CLK);
    valid = 1'b0;
    check("ovf_count_e18", fifo_count, DEPTH);
    check("ovf_full_e18", fifo_full, 1'b1);
    check("ovf_flag_set", overflow, 1'b1);
    wait_frames(f0 + 17, 17 * 10 * CPB + 50);
    check("ovf_flag_sticky", overflow, 1'b1);
    check("ovf_sb_empty", exp_q.size(), 0);
    do_reset(1);
    check("ovf_flag_cleared", overflow, 1'b0);

    // Full FIFO with a write on the edge where STOP ends and pops
    f0 = frames;
    @(negedge CLK);
    valid = 1'b1;
    char_in = 8'h7E;
    exp_q.push_back(8'h7E);
    @(negedge CLK);
    valid = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1;
      char_in = 8'h80 + 8'(i);
      exp_q.push_back(8'h80 + 8'(i));
      @(negedge CLK);
    end
    valid = 1'b0;
    check("full_count", fifo_count, DEPTH);
    check("full_flag", fifo_full, 1'b1);
    repeat (23) @(negedge CLK);
    valid = 1'b1;
    char_in = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge CLK);
    valid = 1'b0;
    check("full_pop_count", fifo_count, DEPTH);
    check("full_pop_flag", fifo_full, 1'b1);
    check("full_pop_overflow", overflow, 1'b0);
    wait_frames(f0 + 18, 18 * 10 * CPB + 50);
    check("full_sb_empty", exp_q.size(), 0);
    check("full_overflow_end", overflow, 1'b0);

    // Reset during data bit 3 with a second byte buffered
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    valid = 1'b1;
    char_in = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge CLK);
    char_in = 8'h66;
    exp_q.push_back(8'h66);
    @(negedge CLK);
    valid = 1'b0;
    repeat (16) @(negedge CLK);
    check("midrst_busy_before", busy, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 0);
    check("midrst_full", fifo_full, 1'b0);
    f0 = frames;
    @(negedge CLK);
    valid = 1'b1;
    char_in = 8'h41;
    exp_q.push_back(8'h41);
    @(negedge CLK);
    valid = 1'b0;
    wait_frames(f0 + 1, 100);
    repeat (3) @(negedge CLK);
    check("midrst_sb_empty", exp_q.size(), 0);
    check("midrst_frames_after", frames, f0 + 1);
    check("midrst_busy_end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
